ms_dbg_mem_arb: RTL and testbench

MS_DBG_MEM_ARB -- requirements
Module: ms_dbg_mem_arb

---
 rtl/ms_dbg_pkg.sv | 23 ++
 rtl/ms_rr_arb2.sv | 35 +++
 rtl/ms_dbg_mem_arb.sv | 235 +++++++++++++++++++++++
 tb/tb_ms_dbg_mem_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_dbg_pkg.sv
// Shared encodings for the debug/loader memory arbiter: FSM states,
// bus widths and the {WrEn, RdEn} field layout.
package ms_dbg_pkg;

  localparam int unsigned CAddrW = 29;
  localparam int unsigned CDataW = 64;

  localparam int unsigned CWrBit = 1;
  localparam int unsigned CRdBit = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ms_arb_state_e;

  // A well-formed request asks for exactly one of write or read.
  function automatic logic f_wrrden_ok(input logic [1:0] wrrden);
    return wrrden[CWrBit] ^ wrrden[CRdBit];
  endfunction

endpackage

// File: rtl/ms_rr_arb2.sv
// Two-requester round-robin selector; the side served last loses a tie.
// Bit 0 is the debug unit (U), bit 1 the loader (L).
module ms_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_last_l,
  output logic [1:0] o_gnt
);

  logic r_ptr_l;

  // Preference pointer: set to L after U was served, back to U after L.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr_l <= 1'b0;
    end else if (i_en && i_upd) begin
      r_ptr_l <= ~i_last_l;
    end
  end

  // One-hot grant from the current requests and the preference pointer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr_l ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ms_dbg_mem_arb.sv
// Shares one 64-bit memory port between the debug unit (U) and the loader (L):
// one beat in flight, locked bursts capped by a fairness count, ack timeout.
module ms_dbg_mem_arb
  import ms_dbg_pkg::*;
#(
  parameter int unsigned CTimeoutLen = 8,
  parameter int unsigned CFairHold   = 4
) (
  input  logic              i_AClkH,
  input  logic              i_AResetH,
  input  logic              i_AClkHEn,
  input  logic              i_AReqU,
  input  logic              i_AReqL,
  input  logic              i_ALockU,
  input  logic              i_ALockL,
  input  logic [CAddrW-1:0] i_AAddrU,
  input  logic [CAddrW-1:0] i_AAddrL,
  input  logic [CDataW-1:0] i_AMosiU,
  input  logic [CDataW-1:0] i_AMosiL,
  input  logic [1:0]        i_AWrRdEnU,
  input  logic [1:0]        i_AWrRdEnL,
  output logic              o_AGntU,
  output logic              o_AGntL,
  output logic              o_AAckU,
  output logic              o_AAckL,
  output logic              o_AErrU,
  output logic              o_AErrL,
  output logic [CDataW-1:0] o_AMisoR,
  output logic              o_AMemAccess,
  output logic [CAddrW-1:0] o_AMemAddr,
  output logic [CDataW-1:0] o_AMemMosi,
  output logic [1:0]        o_AMemWrRdEn,
  input  logic [CDataW-1:0] i_AMemMiso,
  input  logic              i_AMemAck
);

  localparam int unsigned CHoldW = $clog2(CFairHold + 1);
  localparam logic [CHoldW-1:0]      CHoldMax = CHoldW'(CFairHold);
  localparam logic [CHoldW-1:0]      CHoldOne = CHoldW'(1);
  localparam logic [CTimeoutLen-1:0] CToLast  = {CTimeoutLen{1'b1}};

  ms_arb_state_e           r_state, w_state_nxt;
  logic                    r_owner_l, w_owner_l_nxt;
  logic                    r_gnt_u, w_gnt_u_nxt, r_gnt_l, w_gnt_l_nxt;
  logic                    r_ack_u, w_ack_u_nxt, r_ack_l, w_ack_l_nxt;
  logic                    r_err_u, w_err_u_nxt, r_err_l, w_err_l_nxt;
  logic [CDataW-1:0]       r_miso, w_miso_nxt;
  logic                    r_access, w_access_nxt;
  logic [CAddrW-1:0]       r_addr, w_addr_nxt;
  logic [CDataW-1:0]       r_mosi, w_mosi_nxt;
  logic [1:0]              r_wrrden, w_wrrden_nxt;
  logic [CHoldW-1:0]       r_hold, w_hold_nxt, w_hold_inc;
  logic [CTimeoutLen-1:0]  r_to, w_to_nxt, w_to_inc;

  logic              w_req_u, w_req_l, w_ptr_upd, w_sel_l;
  logic [1:0]        w_arb_gnt;
  logic              w_own_req, w_own_lock, w_oth_req;
  logic [CAddrW-1:0] w_sel_addr;
  logic [CDataW-1:0] w_sel_mosi;
  logic [1:0]        w_sel_wrrden;

  // Malformed {WrEn, RdEn} codes are never arbitrated.
  assign w_req_u = i_AReqU & f_wrrden_ok(i_AWrRdEnU);
  assign w_req_l = i_AReqL & f_wrrden_ok(i_AWrRdEnL);

  assign w_to_inc   = r_to + 1'b1;
  assign w_hold_inc = (r_hold == CHoldMax) ? CHoldMax : r_hold + 1'b1;

  ms_rr_arb2 u_rr (
    .i_clk    (i_AClkH),
    .i_rst    (i_AResetH),
    .i_en     (i_AClkHEn),
    .i_req    ({w_req_l, w_req_u}),
    .i_upd    (w_ptr_upd),
    .i_last_l (r_owner_l),
    .o_gnt    (w_arb_gnt)
  );

  // Requester mux: the arbiter's choice while idle, the current owner otherwise.
  always_comb begin
    w_sel_l = (r_state == ST_IDLE) ? w_arb_gnt[1] : r_owner_l;
    if (w_sel_l) begin
      w_sel_addr   = i_AAddrL;
      w_sel_mosi   = i_AMosiL;
      w_sel_wrrden = i_AWrRdEnL;
      w_own_req    = w_req_l;
      w_own_lock   = i_ALockL;
      w_oth_req    = w_req_u;
    end else begin
      w_sel_addr   = i_AAddrU;
      w_sel_mosi   = i_AMosiU;
      w_sel_wrrden = i_AWrRdEnU;
      w_own_req    = w_req_u;
      w_own_lock   = i_ALockU;
      w_oth_req    = w_req_l;
    end
  end

  // Next-state and next-output logic for the beat sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_l_nxt = r_owner_l;
    w_gnt_u_nxt   = r_gnt_u;
    w_gnt_l_nxt   = r_gnt_l;
    w_ack_u_nxt   = 1'b0;
    w_ack_l_nxt   = 1'b0;
    w_err_u_nxt   = 1'b0;
    w_err_l_nxt   = 1'b0;
    w_miso_nxt    = r_miso;
    w_access_nxt  = 1'b0;
    w_addr_nxt    = {CAddrW{1'b0}};
    w_mosi_nxt    = {CDataW{1'b0}};
    w_wrrden_nxt  = 2'b00;
    w_hold_nxt    = r_hold;
    w_to_nxt      = r_to;
    w_ptr_upd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_gnt != 2'b00) begin
          w_state_nxt   = ST_ISSUE;
          w_owner_l_nxt = w_arb_gnt[1];
          w_gnt_u_nxt   = w_arb_gnt[0];
          w_gnt_l_nxt   = w_arb_gnt[1];
          w_access_nxt  = 1'b1;
          w_addr_nxt    = w_sel_addr;
          w_mosi_nxt    = w_sel_mosi;
          w_wrrden_nxt  = w_sel_wrrden;
          w_hold_nxt    = CHoldOne;
        end else begin
          w_gnt_u_nxt = 1'b0;
          w_gnt_l_nxt = 1'b0;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (i_AMemAck) begin
          w_state_nxt = ST_DONE;
          w_ack_u_nxt = ~r_owner_l;
          w_ack_l_nxt = r_owner_l;
          w_miso_nxt  = i_AMemMiso;
        end else if (r_state == ST_ISSUE) begin
          w_state_nxt  = ST_WAIT;
          w_access_nxt = 1'b1;
          w_addr_nxt   = r_addr;
          w_mosi_nxt   = r_mosi;
          w_to_nxt     = {CTimeoutLen{1'b0}};
        end else if (w_to_inc == CToLast) begin
          // Memory never answered: abort the beat and hand the bus back.
          w_state_nxt = ST_IDLE;
          w_err_u_nxt = ~r_owner_l;
          w_err_l_nxt = r_owner_l;
          w_gnt_u_nxt = 1'b0;
          w_gnt_l_nxt = 1'b0;
          w_ptr_upd   = 1'b1;
          w_hold_nxt  = {CHoldW{1'b0}};
        end else begin
          w_to_nxt     = w_to_inc;
          w_access_nxt = 1'b1;
          w_addr_nxt   = r_addr;
          w_mosi_nxt   = r_mosi;
        end
      end
      ST_DONE: begin
        if (w_own_lock && w_own_req && ((r_hold < CHoldMax) || !w_oth_req)) begin
          w_state_nxt  = ST_ISSUE;
          w_access_nxt = 1'b1;
          w_addr_nxt   = w_sel_addr;
          w_mosi_nxt   = w_sel_mosi;
          w_wrrden_nxt = w_sel_wrrden;
          w_hold_nxt   = w_hold_inc;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_u_nxt = 1'b0;
          w_gnt_l_nxt = 1'b0;
          w_ptr_upd   = 1'b1;
          w_hold_nxt  = {CHoldW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_u_nxt = 1'b0;
        w_gnt_l_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over the clock enable.
  always_ff @(posedge i_AClkH) begin
    if (i_AResetH) begin
      r_state   <= ST_IDLE;
      r_owner_l <= 1'b0;
      r_gnt_u   <= 1'b0;
      r_gnt_l   <= 1'b0;
      r_ack_u   <= 1'b0;
      r_ack_l   <= 1'b0;
      r_err_u   <= 1'b0;
      r_err_l   <= 1'b0;
      r_miso    <= {CDataW{1'b0}};
      r_access  <= 1'b0;
      r_addr    <= {CAddrW{1'b0}};
      r_mosi    <= {CDataW{1'b0}};
      r_wrrden  <= 2'b00;
      r_hold    <= {CHoldW{1'b0}};
      r_to      <= {CTimeoutLen{1'b0}};
    end else if (i_AClkHEn) begin
      r_state   <= w_state_nxt;
      r_owner_l <= w_owner_l_nxt;
      r_gnt_u   <= w_gnt_u_nxt;
      r_gnt_l   <= w_gnt_l_nxt;
      r_ack_u   <= w_ack_u_nxt;
      r_ack_l   <= w_ack_l_nxt;
      r_err_u   <= w_err_u_nxt;
      r_err_l   <= w_err_l_nxt;
      r_miso    <= w_miso_nxt;
      r_access  <= w_access_nxt;
      r_addr    <= w_addr_nxt;
      r_mosi    <= w_mosi_nxt;
      r_wrrden  <= w_wrrden_nxt;
      r_hold    <= w_hold_nxt;
      r_to      <= w_to_nxt;
    end
  end

  assign o_AGntU      = r_gnt_u;
  assign o_AGntL      = r_gnt_l;
  assign o_AAckU      = r_ack_u;
  assign o_AAckL      = r_ack_l;
  assign o_AErrU      = r_err_u;
  assign o_AErrL      = r_err_l;
  assign o_AMisoR     = r_miso;
  assign o_AMemAccess = r_access;
  assign o_AMemAddr   = r_addr;
  assign o_AMemMosi   = r_mosi;
  assign o_AMemWrRdEn = r_wrrden;

endmodule

// File: tb/tb_ms_dbg_mem_arb.sv
// Directed bench for ms_dbg_mem_arb: hand-computed cycle counts and values,
// with a negedge monitor counting pulses and exclusivity violations.
module tb_ms_dbg_mem_arb;

  localparam int SIG_ACK_U = 0;
  localparam int SIG_ACK_L = 1;
  localparam int SIG_ERR_L = 2;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        req_u, req_l, lock_u, lock_l;
  logic [28:0] addr_u, addr_l;
  logic [63:0] mosi_u, mosi_l;
  logic [1:0]  wr_u, wr_l;
  logic        gnt_u, gnt_l, ack_u, ack_l, err_u, err_l;
  logic [63:0] miso_r;
  logic        mem_access;
  logic [28:0] mem_addr;
  logic [63:0] mem_mosi;
  logic [1:0]  mem_wrrden;
  logic [63:0] mem_miso;
  logic        mem_ack, mem_ack_man, mem_auto;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack_u = 0, n_ack_l = 0, n_err_l = 0, n_both_gnt = 0, n_mem_leak = 0;

  always #5 clk = ~clk;

  // Memory model: either acks in the same cycle it is accessed, or is driven by hand.
  assign mem_ack = mem_auto ? mem_access : mem_ack_man;

  ms_dbg_mem_arb #(.CTimeoutLen(8), .CFairHold(4)) dut (
    .i_AClkH(clk), .i_AResetH(rst), .i_AClkHEn(en),
    .i_AReqU(req_u), .i_AReqL(req_l), .i_ALockU(lock_u), .i_ALockL(lock_l),
    .i_AAddrU(addr_u), .i_AAddrL(addr_l), .i_AMosiU(mosi_u), .i_AMosiL(mosi_l),
    .i_AWrRdEnU(wr_u), .i_AWrRdEnL(wr_l),
    .o_AGntU(gnt_u), .o_AGntL(gnt_l), .o_AAckU(ack_u), .o_AAckL(ack_l),
    .o_AErrU(err_u), .o_AErrL(err_l), .o_AMisoR(miso_r),
    .o_AMemAccess(mem_access), .o_AMemAddr(mem_addr), .o_AMemMosi(mem_mosi),
    .o_AMemWrRdEn(mem_wrrden), .i_AMemMiso(mem_miso), .i_AMemAck(mem_ack)
  );

  always @(negedge clk) begin
    if (ack_u) n_ack_u++;
    if (ack_l) n_ack_l++;
    if (err_l) n_err_l++;
    if (gnt_u && gnt_l) n_both_gnt++;
    if (!mem_access && (mem_addr != 29'd0 || mem_mosi != 64'd0 || mem_wrrden != 2'b00)) n_mem_leak++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en = 1'b1; req_u = 1'b0; req_l = 1'b0; lock_u = 1'b0; lock_l = 1'b0;
    addr_u = 29'd0; addr_l = 29'd0; mosi_u = 64'd0; mosi_l = 64'd0;
    wr_u = 2'b00; wr_l = 2'b00; mem_miso = 64'd0; mem_ack_man = 1'b0; mem_auto = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      SIG_ACK_U: return ack_u;
      SIG_ACK_L: return ack_l;
      SIG_ERR_L: return err_l;
      default:   return 1'b0;
    endcase
  endfunction

  // Edges until the selected output is seen high; -1 if the budget expires.
  task automatic wait_for(input int sel, input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (sig_sel(sel)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, u_beats, l_beats, first_l, u_at_l, resumed, base_ack, base_err;

    // Reset with the clock enable low must still clear everything.
    clear_inputs();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_ctl", {gnt_u, gnt_l, ack_u, ack_l, err_u, err_l, mem_access}, 64'd0);
    check_eq("rst_mem", {mem_addr, mem_wrrden}, 64'd0);
    check_eq("rst_mosi", mem_mosi, 64'd0);
    check_eq("rst_miso", miso_r, 64'd0);
    rst = 1'b0;
    en  = 1'b1;

    // U read at byte 0x100, memory acks during ISSUE: ack in the third cycle.
    req_u = 1'b1; addr_u = 29'h20; wr_u = 2'b01;
    mem_auto = 1'b1; mem_miso = 64'h1122334455667788;
    tick();
    check_eq("t1_gnt", {gnt_u, gnt_l}, 64'h2);
    check_eq("t1_issue", {mem_access, mem_wrrden}, 64'h5);
    check_eq("t1_addr", mem_addr, 64'h20);
    req_u = 1'b0;
    tick();
    check_eq("t1_ack", {ack_u, ack_l, mem_access}, 64'h4);
    check_eq("t1_miso", miso_r, 64'h1122334455667788);
    tick();
    check_eq("t1_release", {gnt_u, ack_u}, 64'd0);

    // Tie after reset goes to U, then L, then U again.
    do_reset();
    req_u = 1'b1; addr_u = 29'h11; wr_u = 2'b01;
    req_l = 1'b1; addr_l = 29'h22; wr_l = 2'b01;
    mem_auto = 1'b1;
    tick();
    check_eq("t2_first_u", {gnt_u, gnt_l}, 64'h2);
    tick(); tick(); tick();
    check_eq("t2_then_l", {gnt_u, gnt_l}, 64'h1);
    check_eq("t2_l_addr", mem_addr, 64'h22);
    tick();
    check_eq("t2_ack_l", ack_l, 64'h1);
    tick(); tick();
    check_eq("t2_tie_u", {gnt_u, gnt_l}, 64'h2);
    req_u = 1'b0; req_l = 1'b0;
    tick(); tick(); tick();

    // U locked 10-beat burst with L waiting: L cuts in after U's 4th beat.
    do_reset();
    req_u = 1'b1; lock_u = 1'b1; addr_u = 29'd0; wr_u = 2'b01;
    req_l = 1'b1; addr_l = 29'h1234; wr_l = 2'b01;
    mem_auto = 1'b1;
    u_beats = 0; l_beats = 0; first_l = -1; u_at_l = -1; resumed = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (gnt_l && first_l < 0) begin
        first_l = c;
        u_at_l  = u_beats;
      end
      if (gnt_u && first_l >= 0) resumed = 1;
      if (ack_u) begin
        u_beats++;
        addr_u = 29'(u_beats);
        if (u_beats == 10) begin
          req_u  = 1'b0;
          lock_u = 1'b0;
        end
      end
      if (ack_l) begin
        l_beats++;
        req_l = 1'b0;
      end
    end
    check_eq("t3_l_after_4", 64'(u_at_l), 64'd4);
    check_eq("t3_l_grant_cycle", 64'(first_l), 64'd10);
    check_eq("t3_u_beats", 64'(u_beats), 64'd10);
    check_eq("t3_l_beats", 64'(l_beats), 64'd1);
    check_eq("t3_u_resumed", 64'(resumed), 64'd1);

    // Memory never acks: L aborts after 255 WAIT cycles, no ack.
    do_reset();
    req_l = 1'b1; addr_l = 29'h55; wr_l = 2'b01;
    base_ack = n_ack_l;
    base_err = n_err_l;
    tick();
    check_eq("t4_gnt_l", gnt_l, 64'h1);
    req_l = 1'b0;
    wait_for(SIG_ERR_L, 400, cyc);
    // Counted from the ISSUE cycle: one ISSUE-to-WAIT edge plus 255 WAIT cycles.
    check_eq("t4_err_cycle", 64'(cyc), 64'd256);
    check_eq("t4_bus_off", {mem_access, gnt_l, ack_l}, 64'd0);
    tick();
    check_eq("t4_err_pulse", err_l, 64'd0);
    check_eq("t4_no_ack", 64'(n_ack_l - base_ack), 64'd0);
    check_eq("t4_err_count", 64'(n_err_l - base_err), 64'd1);

    // Clock enable low in WAIT with ack held: frozen, ack taken on first enabled edge.
    do_reset();
    req_u = 1'b1; addr_u = 29'h77; wr_u = 2'b01;
    tick();
    tick();
    check_eq("t5_wait_bus", {mem_access, mem_wrrden}, 64'h4);
    check_eq("t5_wait_addr", mem_addr, 64'h77);
    req_u = 1'b0;
    en = 1'b0;
    mem_ack_man = 1'b1;
    mem_miso = 64'hCAFEF00D01234567;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t5_frozen", {ack_u, mem_access, gnt_u}, 64'h3);
    en = 1'b1;
    tick();
    check_eq("t5_ack", ack_u, 64'h1);
    check_eq("t5_miso", miso_r, 64'hCAFEF00D01234567);
    mem_ack_man = 1'b0;
    tick();
    check_eq("t5_release", gnt_u, 64'd0);

    // Reset in WAIT abandons the beat; a fresh request then completes normally.
    req_u = 1'b1; addr_u = 29'h99; wr_u = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t6_rst_ctl", {gnt_u, gnt_l, ack_u, ack_l, err_u, err_l, mem_access}, 64'd0);
    check_eq("t6_rst_mem", {mem_addr, mem_wrrden}, 64'd0);
    check_eq("t6_rst_miso", miso_r, 64'd0);
    rst = 1'b0;
    addr_u = 29'hAA;
    mem_auto = 1'b1;
    mem_miso = 64'h0F0E0D0C0B0A0908;
    wait_for(SIG_ACK_U, 10, cyc);
    req_u = 1'b0;
    check_eq("t6_latency", 64'(cyc), 64'd2);
    check_eq("t6_miso", miso_r, 64'h0F0E0D0C0B0A0908);
    tick();

    // L write: data and WrEn forwarded onto the memory port.
    tick();
    req_l = 1'b1; addr_l = 29'h3; mosi_l = 64'hDEADBEEF0BADF00D; wr_l = 2'b10;
    tick();
    check_eq("t7_wr_bus", {mem_access, mem_wrrden}, 64'h6);
    check_eq("t7_mosi", mem_mosi, 64'hDEADBEEF0BADF00D);
    req_l = 1'b0;
    wait_for(SIG_ACK_L, 10, cyc);
    check_eq("t7_ack_l", 64'(cyc), 64'd1);
    tick();
    tick();

    check_eq("no_dual_grant", 64'(n_both_gnt), 64'd0);
    check_eq("mem_zero_when_idle", 64'(n_mem_leak), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
